// File: rtl/vernam_decrypt_if.sv
// Key, ciphertext and plaintext valid/ready streams of the Vernam decryptor.
// master = stream driver side, slave = decryptor side.
interface vernam_decrypt_if;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_ready;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready;

  modport master (
    output key_data, key_valid,
    output ct_data, ct_valid,
    output pt_ready,
    input  key_ready, ct_ready,
    input  pt_data, pt_valid
  );

  modport slave (
    input  key_data, key_valid,
    input  ct_data, ct_valid,
    input  pt_ready,
    output key_ready, ct_ready,
    output pt_data, pt_valid
  );
endinterface

// File: rtl/vernam_decrypt.sv
// One-time-pad decryptor: key FIFO, XOR with oldest key, registered pt stream.
// Optional running checksum enabled by VERNAM_DEC_CHECKSUM_EN.
module vernam_decrypt #(
  parameter int KEY_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  vernam_decrypt_if.slave              bus,
  output logic [$clog2(KEY_DEPTH):0]   key_level,
  output logic [15:0]                  byte_count,
  output logic [7:0]                   checksum
);
  localparam int AW = $clog2(KEY_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(KEY_DEPTH);

  logic [7:0]    mem [KEY_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic [7:0]    pt_q;
  logic          pt_v;
  logic          push;
  logic          pop;
  logic          drain;

  assign bus.key_ready = (level != FULL);
  assign bus.ct_ready  = (level != '0) &&
                         (!pt_v || bus.pt_ready);

  assign push  = bus.key_valid && bus.key_ready;
  assign pop   = bus.ct_valid && bus.ct_ready;
  assign drain = pt_v && bus.pt_ready;

  assign bus.pt_data  = pt_q;
  assign bus.pt_valid = pt_v;
  assign key_level    = level;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.key_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pt_q <= 8'h00;
      pt_v <= 1'b0;
    end else if (pop) begin
      pt_q <= bus.ct_data ^ mem[rd_ptr];
      pt_v <= 1'b1;
    end else if (drain) begin
      pt_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      byte_count <= 16'h0000;
    else if (drain)
      byte_count <= byte_count + 16'h0001;
  end

`ifdef VERNAM_DEC_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset)
      sum_q <= 8'h00;
    else if (drain)
      sum_q <= sum_q ^ pt_q;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_vernam_decrypt.sv
// Self-checking bench for vernam_decrypt: vector table, corner sequences
// and random traffic against a queue-based reference model.
module tb_vernam_decrypt;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  key_level;
  logic [15:0] byte_count;
  logic [7:0]  checksum;

  vernam_decrypt_if bus ();

  vernam_decrypt #(.KEY_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .key_level  (key_level),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model
  byte unsigned kq[$];
  logic         m_valid;
  logic [7:0]   m_pt;
  logic [15:0]  m_count;
  logic [7:0]   m_sum;

  typedef struct {
    logic [7:0] key;
    logic [7:0] ct;
    logic [7:0] pt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    check("pt_valid", 32'(bus.pt_valid), 32'(m_valid));
    check("pt_data", 32'(bus.pt_data), 32'(m_pt));
    check("key_level", 32'(key_level), kq.size());
    check("byte_count", 32'(byte_count), 32'(m_count));
`ifdef VERNAM_DEC_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(m_sum));
`else
    check("checksum", 32'(checksum), 32'h0);
`endif
  endtask

  // Caller is at posedge+1; returns at next posedge+1.
  task automatic step(input logic kv, input logic [7:0] kd,
                      input logic cv, input logic [7:0] cd,
                      input logic pr);
    bit push, pop, drain;
    logic [7:0] k;
    bus.key_valid = kv;
    bus.key_data  = kd;
    bus.ct_valid  = cv;
    bus.ct_data   = cd;
    bus.pt_ready  = pr;
    #3;
    drain = m_valid && pr;
    pop   = cv && kq.size() != 0 && (!m_valid || pr);
    push  = kv && kq.size() != DEPTH;
    check("key_ready", 32'(bus.key_ready), kq.size() != DEPTH);
    check("ct_ready", 32'(bus.ct_ready),
          kq.size() != 0 && (!m_valid || pr));
    if (drain) begin
      m_count = m_count + 16'd1;
      m_sum   = m_sum ^ m_pt;
    end
    if (pop) begin
      k       = kq.pop_front();
      m_pt    = cd ^ k;
      m_valid = 1'b1;
    end else if (drain) begin
      m_valid = 1'b0;
    end
    if (push)
      kq.push_back(kd);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.ct_valid  = 1'b0;
    bus.pt_ready  = 1'b0;
    bus.key_data  = 8'h00;
    bus.ct_data   = 8'h00;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    kq.delete();
    m_valid = 1'b0;
    m_pt    = 8'h00;
    m_count = 16'h0;
    m_sum   = 8'h00;
    check_outs();
    check("rst_key_ready", 32'(bus.key_ready), 32'h1);
    check("rst_ct_ready", 32'(bus.ct_ready), 32'h0);
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 8'h66};
    vecs[1] = '{8'hFF, 8'h0F, 8'hF0};
    vecs[2] = '{8'h00, 8'hAB, 8'hAB};
    vecs[3] = '{8'hA5, 8'hA5, 8'h00};
    vecs[4] = '{8'h01, 8'hFE, 8'hFF};

    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // table: key, then ct, then drain
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].key, 1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1, vecs[i].ct, 1'b1);
      check("vec_pt", 32'(bus.pt_data), 32'(vecs[i].pt));
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    check("vec_count", 32'(byte_count), 32'd5);

    // ct offered with no keys
    for (int i = 0; i < 10; i++)
      step(1'b0, 8'h00, 1'b1, 8'h0F, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 8'h0F, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h0F, 1'b1);
    check("empty_pt", 32'(bus.pt_data), 32'hF0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // fill (pointers already offset), 17th rejected, wrap drain
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b1);
    check("full_level", 32'(key_level), 32'd16);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 8'h00, 1'b1, 8'($urandom), 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("wrap_level", 32'(key_level), 32'd0);

    // output stall
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'(8'h30 + i), 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 8'h00, 1'b1, 8'h11, 1'b0);
    check("stall_pt", 32'(bus.pt_data), 32'(8'h77 ^ 8'h30));
    check("stall_level", 32'(key_level), 32'd2);
    step(1'b0, 8'h00, 1'b1, 8'h11, 1'b1);
    check("release_pt", 32'(bus.pt_data), 32'(8'h11 ^ 8'h31));
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h44, 1'b0);
    check("pre_rst_level", 32'(key_level), 32'd5);
    do_reset();

    // checksum of 01,02,04
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h01, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h02, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h04, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`ifdef VERNAM_DEC_CHECKSUM_EN
    check("cksum_07", 32'(checksum), 32'h07);
`else
    check("cksum_00", 32'(checksum), 32'h00);
`endif

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 8'($urandom), 1'($urandom),
           8'($urandom), 1'($urandom_range(0, 3) != 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vernam_decrypt.md
# vernam_decrypt

Receive-side Vernam (one-time-pad) engine that recovers plaintext from the ciphertext produced by the encrypting PicoBlaze. It buffers key bytes from the random-generator side in a small FIFO and XORs each arriving ciphertext byte with the oldest unused key byte. It emits plaintext on a registered valid/ready stream. It sits between the ciphertext/key sources and the consumer PicoBlaze port logic, one instance per link.

## Interface
- KEY_DEPTH, 16, key FIFO depth in bytes; must be a power of two, ≥ 2
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- key_data  in  8  key byte from the random source
- key_valid  in  1  key_data is valid
- key_ready  out  1  FIFO can accept a key byte
- ct_data  in  8  ciphertext byte
- ct_valid  in  1  ct_data is valid
- ct_ready  out  1  engine can accept a ciphertext byte
- pt_data  out  8  plaintext byte
- pt_valid  out  1  pt_data is valid
- pt_ready  in  1  downstream accepts pt_data
- key_level  out  $clog2(KEY_DEPTH)+1  key bytes currently buffered
- byte_count  out  16  plaintext bytes emitted since reset
- checksum  out  8  running XOR of emitted plaintext (see Configuration)

## Operation
- Key push: key_valid && key_ready. key_ready = (key_level != KEY_DEPTH); it derives from registered level only, with no pass-through from a same-cycle pop.
- Ciphertext accept: ct_valid && ct_ready. ct_ready = (key_level != 0) && (!pt_valid || pt_ready).
- On accept: pt_data ← ct_data ^ key_head; pop key FIFO; pt_valid ← 1.
- pt_valid clears on pt_valid && pt_ready with no accept in the same cycle. Accept and drain together keep pt_valid = 1 with the new data.
- Key FIFO: circular buffer with read/write pointers that wrap modulo KEY_DEPTH. Simultaneous push and pop leave key_level unchanged. A key push into an empty FIFO cannot be consumed in the same cycle.
- byte_count increments on every pt handshake (pt_valid && pt_ready) and wraps 16'hFFFF → 0.
- Key bytes are never reused: each pop is final, including for ciphertext that is later stalled at the output.
- Reset mid-operation discards buffered keys and any pending pt byte. No partial state survives.

## Timing
- Reset values: key_ready = 1, ct_ready = 0, pt_valid = 0, pt_data = 8'h00, key_level = 0, byte_count = 0, checksum = 8'h00. All pointers are 0.
- Latency: a ct accepted at cycle N appears as pt_valid/pt_data at cycle N+1.
- Throughput: 1 byte/cycle sustained while keys are available and pt_ready = 1.
- Stall: while pt_valid && !pt_ready, pt_data is held stable and ct_ready = 0.
- key_level updates the cycle after a push or pop.
- All outputs are registered except key_ready and ct_ready, which are combinational from registered state plus pt_ready.

## Configuration
- VERNAM_DEC_CHECKSUM_EN defined:
  - checksum ← checksum ^ pt_data on every pt handshake.
  - Reset clears it to 8'h00.
  - It wraps naturally as an 8-bit XOR.
- Not defined: the checksum register is not built and the checksum port is constant 8'h00.

## Test plan
- Reset, then push key 8'h5A and ct 8'h3C at cycle 2 with pt_ready = 1 → pt_data = 8'h66 with pt_valid at cycle 3; key_level returns to 0; byte_count = 1.
- ct_valid held high with an empty key FIFO for 10 cycles → ct_ready = 0 throughout, no pt_valid. Push key 8'hFF → ct_ready rises the next cycle, and ct 8'h0F yields 8'hF0.
- Fill 16 keys (KEY_DEPTH = 16), then offer a 17th → key_ready = 0 and the 17th byte is not stored. Decrypt 16 bytes back-to-back → pointer wrap is correct and plaintext matches the reference XOR stream.
- Hold pt_ready = 0 with one pt pending → pt_data stays stable, ct_ready = 0, and no key is popped. Release → 1-cycle drain and accept.
- Assert reset with 5 keys buffered and pt_valid = 1 → next cycle key_level = 0, pt_valid = 0, byte_count = 0, checksum = 8'h00.
- With VERNAM_DEC_CHECKSUM_EN, decrypt plaintext 8'h01, 8'h02, 8'h04 → checksum = 8'h07. Without the macro → checksum stays 8'h00.
